// File: rtl/rf_run_checker.sv
// Run/check controller: lets the core run for RUN_CYCLES, then freezes it and
// scans the register file against an expected-value table.
module rf_run_checker #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int RUN_CYCLES = 1000,
  parameter int RD_LAT     = 0,
  parameter int CHECK_X0   = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [XLEN-1:0]   exp_data,
  output logic              core_hold,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int CYC_W = $clog2(RUN_CYCLES) + 1;
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1 + RD_LAT);
  localparam logic [IDX_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [IDX_W-1:0]  idx;
  logic [XLEN-1:0]   exp_mem [NUM_REGS];
  logic [ADDR_W-1:0] cmp_addr;
  logic              cmp_en;
  logic              mismatch;
  logic              table_open;
  logic              launch;

  assign table_open = (state == IDLE) || (state == DONE);
  assign launch     = table_open && start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (cyc_cnt == CYC_LAST) state_nxt = CMP;
      CMP:        if (idx == IDX_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // With a registered RF the data lags the address by one cycle, so the
  // compare uses the previous index and the first CMP cycle is a bubble.
  always_comb begin
    cmp_addr = idx[ADDR_W-1:0] - ADDR_W'(RD_LAT);
    cmp_en   = (state == CMP) && ((RD_LAT == 0) || (idx != '0));
    if ((CHECK_X0 == 0) && (cmp_addr == '0)) cmp_en = 1'b0;
    mismatch = cmp_en && (rf_rdata != exp_mem[cmp_addr]);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state           <= IDLE;
      cyc_cnt         <= '0;
      idx             <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cyc_cnt         <= '0;
        idx             <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
      end else begin
        if (state == RUN && cyc_cnt != CYC_LAST) cyc_cnt <= cyc_cnt + CYC_W'(1);
        if (state == CMP && idx != IDX_LAST) idx <= idx + IDX_W'(1);
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + IDX_W'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= cmp_addr;
          end
        end
      end
    end
  end

  // Table is deliberately unreset; it is only writable while the checker is parked.
  always_ff @(posedge clk) begin
    if (exp_we && table_open) exp_mem[exp_addr] <= exp_data;
  end

  assign core_hold = (state != RUN);
  assign busy      = (state == RUN) || (state == CMP);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign rf_raddr  = idx[ADDR_W-1:0];

endmodule

// File: tb/tb_rf_run_checker.sv
// Bench for rf_run_checker: three instances (comb RF, registered RF, x0 skipped)
// checked against a table-compare reference model.
module tb_rf_run_checker;
  localparam int XLEN = 32;
  localparam int NR   = 8;
  localparam int AW   = 3;
  localparam int RC   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb;
  logic [2:0]                start, exp_we;
  logic [2:0][AW-1:0]        exp_addr;
  logic [2:0][XLEN-1:0]      exp_data;
  wire  [2:0]                core_hold, busy, done, pass, first_err_valid;
  wire  [2:0][AW-1:0]        rf_raddr, first_err_addr;
  wire  [2:0][AW:0]          err_count;

  logic [XLEN-1:0] rf_mem  [3][NR];
  logic [XLEN-1:0] exp_mdl [3][NR];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [XLEN-1:0] rd;
    if (g == 1) begin : g_reg
      always @(posedge clk) rd <= rf_mem[g][rf_raddr[g]];
    end else begin : g_comb
      assign rd = rf_mem[g][rf_raddr[g]];
    end
    rf_run_checker #(
      .XLEN(XLEN), .NUM_REGS(NR), .ADDR_W(AW), .RUN_CYCLES(RC),
      .RD_LAT((g == 1) ? 1 : 0), .CHECK_X0((g == 2) ? 0 : 1)
    ) dut (
      .clk(clk), .rstb(rstb), .start(start[g]), .exp_we(exp_we[g]),
      .exp_addr(exp_addr[g]), .exp_data(exp_data[g]), .core_hold(core_hold[g]),
      .rf_raddr(rf_raddr[g]), .rf_rdata(rd), .busy(busy[g]), .done(done[g]),
      .pass(pass[g]), .err_count(err_count[g]), .first_err_valid(first_err_valid[g]),
      .first_err_addr(first_err_addr[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: count of differing registers and lowest differing one.
  task automatic model(input int d, output int errs, output int first);
    errs  = 0;
    first = -1;
    for (int i = 0; i < NR; i++) begin
      if ((d != 2 || i != 0) && rf_mem[d][i] !== exp_mdl[d][i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic load_table(input int d);
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      exp_we[d] = 1'b1; exp_addr[d] = AW'(i); exp_data[d] = exp_mdl[d][i];
    end
    @(negedge clk);
    exp_we[d] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    chk($sformatf("%s/core_hold", tag), core_hold[d], 1);
    chk($sformatf("%s/busy", tag), busy[d], 0);
    chk($sformatf("%s/done", tag), done[d], 0);
    chk($sformatf("%s/pass", tag), pass[d], 0);
    chk($sformatf("%s/err_count", tag), err_count[d], 0);
    chk($sformatf("%s/fev", tag), first_err_valid[d], 0);
    chk($sformatf("%s/fea", tag), first_err_addr[d], 0);
    chk($sformatf("%s/raddr", tag), rf_raddr[d], 0);
  endtask

  task automatic run_check(input int d, input bit poke, input bit wr_run, input bit wr_start,
                           input string tag);
    int errs, first, cyc, hold_low, lat;
    lat = (d == 1) ? 1 : 0;
    @(negedge clk);
    start[d] = 1'b1;
    if (wr_start) begin
      exp_we[d] = 1'b1; exp_addr[d] = 3'd5; exp_data[d] = 32'h5A5A_0005;
      exp_mdl[d][5] = 32'h5A5A_0005;
    end
    model(d, errs, first);
    @(negedge clk);
    start[d] = 1'b0; exp_we[d] = 1'b0;
    chk($sformatf("%s/busy_at_start", tag), busy[d], 1);
    chk($sformatf("%s/err_cleared", tag), err_count[d], 0);
    chk($sformatf("%s/fev_cleared", tag), first_err_valid[d], 0);
    chk($sformatf("%s/done_cleared", tag), done[d], 0);
    cyc = 0; hold_low = 0;
    while (!done[d] && cyc < 100) begin
      if (!core_hold[d]) hold_low++;
      start[d]    = poke && (cyc == 1 || cyc == RC + 2);
      exp_we[d]   = wr_run && (cyc == 1);
      exp_addr[d] = 3'd2;
      exp_data[d] = 32'hBAD0_0002;
      cyc++;
      @(negedge clk);
    end
    start[d] = 1'b0; exp_we[d] = 1'b0;
    chk($sformatf("%s/cycles_to_done", tag), cyc, RC + NR + lat);
    chk($sformatf("%s/hold_low_cycles", tag), hold_low, RC);
    chk($sformatf("%s/done", tag), done[d], 1);
    chk($sformatf("%s/core_hold", tag), core_hold[d], 1);
    chk($sformatf("%s/err_count", tag), err_count[d], errs);
    chk($sformatf("%s/pass", tag), pass[d], errs == 0);
    chk($sformatf("%s/fev", tag), first_err_valid[d], errs != 0);
    chk($sformatf("%s/fea", tag), first_err_addr[d], (first < 0) ? 0 : first);
  endtask

  initial begin
    rstb = 1'b0; start = '0; exp_we = '0; exp_addr = '0; exp_data = '0;
    #1;
    for (int d = 0; d < 3; d++) check_reset_outputs(d, $sformatf("reset%0d", d));
    #24 rstb = 1'b1;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < NR; i++) begin
        exp_mdl[d][i] = XLEN'(i * 32'h11);
        rf_mem[d][i]  = XLEN'(i * 32'h11);
      end
      load_table(d);
    end

    run_check(0, 1'b0, 1'b0, 1'b0, "match");

    rf_mem[0][3] = 32'hDEAD; rf_mem[0][6] = 32'hDEAD;
    run_check(0, 1'b0, 1'b0, 1'b0, "two_bad");
    chk("two_bad/err_const", err_count[0], 2);
    chk("two_bad/fea_const", first_err_addr[0], 3);

    rf_mem[0][3] = 32'h33; rf_mem[0][6] = 32'h66;
    run_check(0, 1'b1, 1'b0, 1'b0, "restart_from_done");
    chk("restart_from_done/pass_const", pass[0], 1);

    rf_mem[1][7] = 32'hDEAD;
    run_check(1, 1'b0, 1'b0, 1'b0, "rdlat1");
    chk("rdlat1/err_const", err_count[1], 1);
    chk("rdlat1/fea_const", first_err_addr[1], 7);

    rf_mem[2][0] = 32'hDEAD;
    run_check(2, 1'b0, 1'b0, 1'b0, "skip_x0");
    chk("skip_x0/pass_const", pass[2], 1);
    run_check(2, 1'b0, 1'b1, 1'b0, "write_in_run");
    run_check(2, 1'b0, 1'b0, 1'b0, "rerun_after_run_write");
    chk("rerun_after_run_write/pass_const", pass[2], 1);
    rf_mem[2][5] = 32'h5A5A_0005;
    run_check(2, 1'b0, 1'b0, 1'b1, "write_with_start");
    chk("write_with_start/pass_const", pass[2], 1);

    // Reset in the middle of CMP with errors already counted.
    rf_mem[0][0] = 32'hBEEF; rf_mem[0][1] = 32'hBEEF;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (RC + 3) @(negedge clk);
    chk("pre_reset/busy", busy[0], 1);
    chk("pre_reset/err_count", err_count[0], 2);
    #2 rstb = 1'b0;
    #1 check_reset_outputs(0, "mid_cmp_reset");
    @(negedge clk); rstb = 1'b1;
    rf_mem[0][0] = 32'h0; rf_mem[0][1] = 32'h11;
    run_check(0, 1'b0, 1'b0, 1'b0, "after_reset");

    for (int it = 0; it < 9; it++) begin
      int d;
      d = it % 3;
      for (int i = 0; i < NR; i++) begin
        exp_mdl[d][i] = $urandom;
        rf_mem[d][i]  = ($urandom_range(0, 3) == 0) ? exp_mdl[d][i] ^ (32'h1 << $urandom_range(0, 31))
                                                    : exp_mdl[d][i];
      end
      load_table(d);
      run_check(d, 1'(($urandom_range(0, 1))), 1'b0, 1'b0, $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
